// File: rtl/karabas_opl3_pkg.sv
// Shared constants and types for the Karabas OPL3 sound card core.
package karabas_opl3_pkg;

  localparam logic [9:0]  PORT_BASE_OPL  = 10'h388;
  localparam logic [9:0]  PORT_BASE_ALT  = 10'h220;
  localparam int unsigned SAMPLE_W       = 16;
  localparam int unsigned SLOTS_PER_HALF = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    FmtLsbJust = 1'b0,
    FmtI2s     = 1'b1
  } dac_fmt_e;

  // Field order matches the cfg bus, enable at bit 0.
  typedef struct packed {
    logic mute;
    logic swap;
    logic fmt;
    logic base_sel;
    logic enable;
  } cfg_t;

  function automatic logic [7:0] port_prefix(input logic base_sel);
    return base_sel ? PORT_BASE_ALT[9:2] : PORT_BASE_OPL[9:2];
  endfunction

endpackage

// File: rtl/karabas_opl3_if.sv
// Z80 I/O bus as seen by the OPL3 card: address/strobes in, chip select and decode status out.
interface karabas_opl3_if;
  logic [9:0] a;
  logic       n_iorq;
  logic       n_m1;
  logic       n_iorqge;
  logic       n_ym_cs;
  logic [1:0] ym_a;

  modport master (output a, n_iorq, n_m1, input n_iorqge, n_ym_cs, ym_a);
  modport slave  (input a, n_iorq, n_m1, output n_iorqge, n_ym_cs, ym_a);
endinterface

// File: rtl/i2s_serializer.sv
// DAC serializer: bit clock / word clock generation and per-frame sample output in I2S or
// LSB-justified format.
module i2s_serializer
  import karabas_opl3_pkg::*;
(
  input  logic    clk28,
  input  logic    rst,
  input  logic    i_fmt,
  input  logic    i_swap,
  input  logic    i_mute,
  input  sample_t i_hold_l,
  input  sample_t i_hold_r,
  output logic    o_bck,
  output logic    o_lrck,
  output logic    o_dat
);

  logic [2:0] r_pre;
  logic [5:0] r_bit;
  sample_t    r_out_l;
  sample_t    r_out_r;
  logic       r_dat;

  logic [5:0] w_bit_nxt;
  logic [4:0] w_slot;
  logic [3:0] w_idx;
  sample_t    w_word;
  logic       w_dat_nxt;

  assign w_bit_nxt = r_bit + 6'd1;

  // Data for the slot that starts at the coming bck falling edge.
  always_comb begin
    w_slot    = w_bit_nxt[4:0];
    w_word    = w_bit_nxt[5] ? r_out_r : r_out_l;
    w_idx     = 4'd0;
    w_dat_nxt = 1'b0;
    if (dac_fmt_e'(i_fmt) == FmtI2s) begin
      if (w_slot >= 5'd1 && w_slot <= 5'd16) begin
        w_idx     = 4'(5'd16 - w_slot);
        w_dat_nxt = w_word[w_idx];
      end
    end else if (w_slot >= 5'd16) begin
      w_idx     = 4'(5'(SLOTS_PER_HALF - 1) - w_slot);
      w_dat_nxt = w_word[w_idx];
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      r_pre   <= 3'd0;
      r_bit   <= 6'd0;
      r_out_l <= '0;
      r_out_r <= '0;
      r_dat   <= 1'b0;
    end else begin
      r_pre <= r_pre + 3'd1;
      if (r_pre == 3'd7) begin
        r_bit <= w_bit_nxt;
        r_dat <= w_dat_nxt;
        if (r_bit == 6'd63) begin
          r_out_l <= i_mute ? '0 : (i_swap ? i_hold_r : i_hold_l);
          r_out_r <= i_mute ? '0 : (i_swap ? i_hold_l : i_hold_r);
        end
      end
    end
  end

  assign o_bck  = r_pre[2];
  assign o_lrck = r_bit[5];
  assign o_dat  = r_dat;

endmodule

// File: rtl/karabas_opl3_core.sv
// YMF262 glue for the Karabas card: Z80 port decode, clock divider, serial sample capture,
// DAC re-serialization and activity LED.
module karabas_opl3_core
  import karabas_opl3_pkg::*;
#(
  parameter int unsigned LED_HOLD_BITS = 22
) (
  input  logic                 clk28,
  input  logic                 rst,
  input  logic [4:0]           cfg,
  karabas_opl3_if.slave        bus,
  output logic                 clk14,
  input  logic [1:0]           ym_smp,
  input  logic                 ym_data,
  input  logic                 ym_dclk,
  output logic                 dac_bck,
  output logic                 dac_lrck,
  output logic                 dac_dat,
  output logic                 dac_std,
  output logic                 led
);

  cfg_t w_cfg;
  logic w_hit;
  logic w_sel;

  assign w_cfg        = cfg_t'(cfg);
  assign w_hit        = w_cfg.enable & (bus.a[9:2] == port_prefix(w_cfg.base_sel));
  assign w_sel        = w_hit & ~bus.n_iorq & bus.n_m1;
  assign bus.n_ym_cs  = ~w_sel;
  assign bus.n_iorqge = ~w_hit;
  assign bus.ym_a     = bus.a[1:0];
  assign dac_std      = w_cfg.fmt;

  // Sync bit map: [0] dclk, [1] data, [2] smp left, [3] smp right.
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_prev;
  logic       r_clk14;
  sample_t    r_shift;
  sample_t    r_hold_l;
  sample_t    r_hold_r;
  logic       r_led;
  logic [LED_HOLD_BITS-1:0] r_led_cnt;

  logic       w_dclk_rise;
  logic [1:0] w_smp_fall;
  sample_t    w_hold_l_d;
  sample_t    w_hold_r_d;

  assign w_dclk_rise = r_sync2[0] & ~r_prev[0];
  assign w_smp_fall  = r_prev[3:2] & ~r_sync2[3:2];
  assign w_hold_l_d  = w_smp_fall[0] ? r_shift : r_hold_l;
  assign w_hold_r_d  = w_smp_fall[1] ? r_shift : r_hold_r;

  always_ff @(posedge clk28) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_clk14   <= 1'b0;
      r_shift   <= '0;
      r_hold_l  <= '0;
      r_hold_r  <= '0;
      r_led     <= 1'b0;
      r_led_cnt <= '0;
    end else begin
      r_sync1  <= {ym_smp, ym_data, ym_dclk};
      r_sync2  <= r_sync1;
      r_prev   <= r_sync2;
      r_clk14  <= ~r_clk14;
      r_hold_l <= w_hold_l_d;
      r_hold_r <= w_hold_r_d;
      if (w_dclk_rise) begin
        r_shift <= {r_shift[SAMPLE_W-2:0], r_sync2[1]};
      end
      // Each access reloads the full hold time; LED drops one cycle after the count empties.
      if (w_sel) begin
        r_led     <= 1'b1;
        r_led_cnt <= '1;
      end else if (r_led_cnt != '0) begin
        r_led_cnt <= r_led_cnt - LED_HOLD_BITS'(1);
      end else begin
        r_led <= 1'b0;
      end
    end
  end

  assign clk14 = r_clk14;
  assign led   = r_led;

  i2s_serializer u_ser (
    .clk28    (clk28),
    .rst      (rst),
    .i_fmt    (w_cfg.fmt),
    .i_swap   (w_cfg.swap),
    .i_mute   (w_cfg.mute),
    .i_hold_l (w_hold_l_d),
    .i_hold_r (w_hold_r_d),
    .o_bck    (dac_bck),
    .o_lrck   (dac_lrck),
    .o_dat    (dac_dat)
  );

endmodule

// File: tb/tb_karabas_opl3_core.sv
// Bench for karabas_opl3_core: cycle-count based reference model checked every negedge,
// plus directed frame captures compared against literal sample words.
module tb_karabas_opl3_core;

  localparam int unsigned HOLD_BITS = 4;
  localparam int          HOLD_CYC  = 1 << HOLD_BITS;

  logic       clk28 = 1'b0;
  logic       rst   = 1'b1;
  logic [4:0] cfg   = 5'b00000;
  logic [1:0] ym_smp  = 2'b11;
  logic       ym_data = 1'b0;
  logic       ym_dclk = 1'b0;
  logic       clk14, dac_bck, dac_lrck, dac_dat, dac_std, led;

  karabas_opl3_if bus ();

  karabas_opl3_core #(.LED_HOLD_BITS(HOLD_BITS)) dut (
    .clk28    (clk28),
    .rst      (rst),
    .cfg      (cfg),
    .bus      (bus),
    .clk14    (clk14),
    .ym_smp   (ym_smp),
    .ym_data  (ym_data),
    .ym_dclk  (ym_dclk),
    .dac_bck  (dac_bck),
    .dac_lrck (dac_lrck),
    .dac_dat  (dac_dat),
    .dac_std  (dac_std),
    .led      (led)
  );

  always #5 clk28 = ~clk28;

  int checks = 0;
  int errors = 0;

  // Model state: t = clk28 edges since reset release, frame payloads, LED age.
  int          t = 0;
  int          cyc = 0;
  int          cfg_cyc = 0;
  int          since_acc = 0;
  logic        acc_seen = 1'b0;
  logic [15:0] m_hold_l = '0, m_hold_r = '0, m_out_l = '0, m_out_r = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d, t %0d)", name, act, exp, cyc, t);
    end
  endtask

  function automatic logic exp_hit(input logic [4:0] c, input logic [9:0] addr);
    int base;
    base = c[1] ? 32'h220 : 32'h388;
    return c[0] && (int'(addr) / 4 == base / 4);
  endfunction

  function automatic logic exp_dat(input int tt, input logic fmt,
                                   input logic [15:0] wl, input logic [15:0] wr);
    int s, h;
    logic [15:0] w;
    s = (tt / 8) % 32;
    h = (tt / 256) % 2;
    w = (h == 1) ? wr : wl;
    if (fmt) return (s >= 1 && s <= 16) ? w[16 - s] : 1'b0;
    return (s >= 16) ? w[31 - s] : 1'b0;
  endfunction

  // Reference model, advanced on every rising edge.
  initial begin
    forever begin
      @(posedge clk28);
      cyc++;
      if (rst) begin
        t = 0;
        m_hold_l = '0; m_hold_r = '0; m_out_l = '0; m_out_r = '0;
        acc_seen = 1'b0; since_acc = 0;
      end else begin
        t++;
        if (t % 512 == 0) begin
          m_out_l = cfg[4] ? 16'h0 : (cfg[3] ? m_hold_r : m_hold_l);
          m_out_r = cfg[4] ? 16'h0 : (cfg[3] ? m_hold_l : m_hold_r);
        end
        if (exp_hit(cfg, bus.a) && !bus.n_iorq && bus.n_m1) begin
          acc_seen = 1'b1; since_acc = 0;
        end else if (acc_seen) begin
          since_acc++;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk28);
      check("n_iorqge", bus.n_iorqge, !exp_hit(cfg, bus.a));
      check("n_ym_cs", bus.n_ym_cs, !(exp_hit(cfg, bus.a) && !bus.n_iorq && bus.n_m1));
      check("ym_a", bus.ym_a, bus.a % 4);
      check("dac_std", dac_std, cfg[2]);
      check("clk14", clk14, t % 2);
      check("dac_bck", dac_bck, (t % 8) >= 4);
      check("dac_lrck", dac_lrck, (t / 256) % 2);
      check("led", led, acc_seen && since_acc < HOLD_CYC);
      if (cyc - cfg_cyc >= 8)
        check("dac_dat", dac_dat, exp_dat(t, cfg[2], m_out_l, m_out_r));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk28);
    #1;
  endtask

  task automatic set_cfg(input logic [4:0] v);
    cfg = v;
    cfg_cyc = cyc;
  endtask

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    while (!((t % 512) == ph && !rst) && k < 1100) begin
      tick(1);
      k++;
    end
    if (k >= 1100) begin
      checks++; errors++;
      $display("FAIL wait_phase: timeout waiting for phase %0d", ph);
    end
  endtask

  task automatic capture_frame(output logic [63:0] bits);
    int k;
    bits = '0;
    k = 0;
    while (!((t % 512) == 0 && !rst) && k < 1100) begin
      @(negedge clk28);
      k++;
    end
    if (k >= 1100) begin
      checks++; errors++;
      $display("FAIL frame_wait: timeout waiting for frame start");
    end
    repeat (512) begin
      @(negedge clk28);
      if (t % 8 == 4) bits[(t / 8) % 64] = dac_dat;
    end
  endtask

  task automatic shift_sample(input logic [15:0] w, input int ch);
    for (int i = 15; i >= 0; i--) begin
      ym_data = w[i];
      tick(3);
      ym_dclk = 1'b1;
      tick(3);
      ym_dclk = 1'b0;
    end
    tick(3);
    ym_smp[ch] = 1'b0;
    tick(4);
    ym_smp[ch] = 1'b1;
    tick(4);
    if (ch == 0) m_hold_l = w; else m_hold_r = w;
  endtask

  task automatic extract(input logic [63:0] bits, input int first, output logic [15:0] w,
                         output int stray, input int lo2, input int hi2);
    w = '0;
    for (int k = 0; k < 16; k++) w[15 - k] = bits[first + k];
    stray = 0;
    for (int s = 0; s < 64; s++)
      if (!((s >= first && s < first + 16) || (s >= lo2 && s <= hi2)) && bits[s]) stray++;
  endtask

  initial begin
    logic [63:0] fr;
    logic [15:0] wl, wr;
    int          st_l, st_r;

    bus.a = 10'h000; bus.n_iorq = 1'b1; bus.n_m1 = 1'b1;
    tick(3);
    @(negedge clk28);
    check("rst_clk14", clk14, 0);
    check("rst_bck", dac_bck, 0);
    check("rst_lrck", dac_lrck, 0);
    check("rst_dat", dac_dat, 0);
    check("rst_led", led, 0);
    tick(1);
    set_cfg(5'b00101);
    rst = 1'b0;

    // I2S: left/right words in slots 1..16 of each half.
    wait_phase(20);
    shift_sample(16'hA5C3, 0);
    shift_sample(16'h1234, 1);
    capture_frame(fr);
    extract(fr, 1, wl, st_l, 33, 48);
    extract(fr, 33, wr, st_r, 1, 16);
    check("i2s_left", wl, 16'hA5C3);
    check("i2s_right", wr, 16'h1234);
    check("i2s_idle_slots", st_l, 0);

    // LSB-justified with channel swap.
    wait_phase(20);
    set_cfg(5'b01001);
    capture_frame(fr);
    extract(fr, 16, wl, st_l, 48, 63);
    extract(fr, 48, wr, st_r, 16, 31);
    check("lj_left", wl, 16'h1234);
    check("lj_right", wr, 16'hA5C3);
    check("lj_idle_slots", st_l, 0);
    check("lj_dac_std", dac_std, 0);

    // Mute on the alternate base.
    wait_phase(20);
    set_cfg(5'b11011);
    capture_frame(fr);
    check("mute_frame", fr[31:0], 0);
    check("mute_frame_hi", fr[63:32], 0);

    // Port access at 0x220.
    set_cfg(5'b11111);
    bus.a = 10'h222; bus.n_iorq = 1'b0; bus.n_m1 = 1'b1;
    @(negedge clk28);
    check("acc_cs", bus.n_ym_cs, 0);
    check("acc_iorqge", bus.n_iorqge, 0);
    check("acc_ym_a", bus.ym_a, 2);
    tick(1);
    bus.n_m1 = 1'b0;
    @(negedge clk28);
    check("acc_led", led, 1);
    check("m1_cs", bus.n_ym_cs, 1);
    check("m1_iorqge", bus.n_iorqge, 0);
    tick(1);
    bus.n_iorq = 1'b1; bus.n_m1 = 1'b1; bus.a = 10'h388;
    @(negedge clk28);
    check("wrong_base_iorqge", bus.n_iorqge, 1);
    tick(8);
    check("led_held", led, 1);
    tick(HOLD_CYC);
    check("led_expired", led, 0);

    // Board disabled: a valid access is ignored.
    set_cfg(5'b11110);
    bus.a = 10'h222; bus.n_iorq = 1'b0;
    tick(3);
    check("dis_cs", bus.n_ym_cs, 1);
    check("dis_iorqge", bus.n_iorqge, 1);
    check("dis_led", led, 0);
    bus.n_iorq = 1'b1;
    set_cfg(5'b00101);

    // Mid-frame reset aborts the frame; the next one starts clean.
    wait_phase(300);
    rst = 1'b1;
    tick(2);
    @(negedge clk28);
    check("mrst_bck", dac_bck, 0);
    check("mrst_lrck", dac_lrck, 0);
    check("mrst_dat", dac_dat, 0);
    tick(1);
    rst = 1'b0;
    capture_frame(fr);
    check("post_rst_frame", fr[31:0], 0);
    check("post_rst_frame_hi", fr[63:32], 0);

    tick(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/karabas_opl3_core.md
KARABAS_OPL3_CORE -- requirements
Module: karabas_opl3_core

Interface
REQ-001 Clocking/reset SHALL be: one clock (clk28); reset rst is synchronous and active-high; all registers in clk28 domain.
REQ-002 Parameter LED_HOLD_BITS, default 22, SHALL set LED stretch counter width (2^22 clk28 cycles).
REQ-003 clk28  in  1  system clock, 28 MHz.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cfg  in  5  [0] board enable, [1] base select (0: 0x388, 1: 0x220), [2] DAC format, [3] L/R swap, [4] mute.
REQ-006 a  in  10  Z80 address bus A[9:0].
REQ-007 n_iorq  in  1  Z80 IORQ, active low.
REQ-008 n_m1  in  1  Z80 M1, active low.
REQ-009 n_iorqge  out  1  low while own port decoded (blocks other I/O devices), else high.
REQ-010 n_ym_cs  out  1  YMF262 chip select, active low.
REQ-011 ym_a  out  2  YMF262 register address A[1:0].
REQ-012 clk14  out  1  YMF262 master clock, clk28/2.
REQ-013 ym_smp  in  2  YMF262 sample strobes, [0] left, [1] right.
REQ-014 ym_data  in  1  YMF262 serial sample data.
REQ-015 ym_dclk  in  1  YMF262 serial bit clock.
REQ-016 dac_bck  out  1  DAC bit clock.
REQ-017 dac_lrck  out  1  DAC word clock, low = left.
REQ-018 dac_dat  out  1  DAC serial data, MSB first.
REQ-019 dac_std  out  1  DAC format pin, equals cfg[2].
REQ-020 led  out  1  activity LED, active high.

Function
REQ-021 hit = cfg[0] & a[9:2]==(cfg[1] ? 0x220 : 0x388)>>2; sel = hit & !n_iorq & n_m1; both combinational.
REQ-022 n_ym_cs = !sel; n_iorqge = !hit; ym_a = a[1:0], combinational, no latency.
REQ-023 clk14 SHALL be a toggle flip-flop on clk28: 0 at reset, then toggles every clk28 rising edge.
REQ-024 ym_dclk, ym_data, ym_smp SHALL each pass a 2-flop synchronizer; edges detected on synchronized values.
REQ-025 On each synchronized ym_dclk rising edge, ym_data SHALL shift into a 16-bit register, MSB first.
REQ-026 On synchronized ym_smp[0] falling edge shift register -> left holding reg; ym_smp[1] falling edge -> right holding reg; both falling same cycle load both.
REQ-027 Serializer: 3-bit prescaler gives dac_bck = clk28/8 (50% duty); 6-bit bit counter gives 64 bck per frame, dac_lrck = counter[5].
REQ-028 At frame start (counter wraps 63->0) holding regs SHALL copy into output regs (swapped if cfg[3], zero if cfg[4]); a strobe coinciding with copy updates holding reg first, new value copied.
REQ-029 dac_dat changes on dac_bck falling edge; cfg[2]=1 (I2S): MSB in slot 1 after lrck edge, bits 1..16, slots 0,17..31 drive 0; cfg[2]=0 (LSB-justified): bits in slots 16..31, LSB in slot 31.
REQ-030 Samples are 16-bit two's complement, passed unmodified; no resampling, last value repeats.
REQ-031 led SHALL go high on any cycle with sel=1 and stay high until LED_HOLD_BITS-wide counter expires with no further access; each access restarts count.
REQ-032 cfg[0]=0: n_ym_cs, n_iorqge held high; audio path keeps running.

Reset
REQ-033 During rst: clk14=0, dac_bck=0, dac_lrck=0, dac_dat=0, led=0, all counters/shift/holding/output regs 0, synchronizers 0.
REQ-034 Reset asserted mid-frame SHALL abort serialization at next clk28 edge; first frame after release starts at slot 0 left with zero data.

Structure
REQ-035 Shared package karabas_opl3_pkg: port base constants 0x388/0x220, sample width 16, slots per half-frame 32.
REQ-036 One sub-module i2s_serializer (prescaler, counters, output regs, format select); decode, capture, LED in top.

Verification
REQ-037 cfg=5'b11111 (0x220), a=0x222, n_iorq=0, n_m1=1 -> n_ym_cs=0, n_iorqge=0, ym_a=2, led=1 next cycle; n_m1=0 -> n_ym_cs=1.
REQ-038 Reset release -> clk14 toggles every clk28 edge, period 2 clk28; dac_bck period 8 clk28; dac_lrck period 512 clk28.
REQ-039 Shift 0xA5C3 on ym_dclk, ym_smp[0] fall; 0x1234, ym_smp[1] fall; cfg[2]=1 -> next frame dac_dat left 0xA5C3 slots 1..16, right 0x1234.
REQ-040 Same samples, cfg[2]=0, cfg[3]=1 -> left slots 16..31 carry 0x1234, right 0xA5C3; dac_std=0.
REQ-041 cfg[4]=1 -> dac_dat constant 0; cfg[0]=0 with valid port access -> n_ym_cs=1, led stays 0.
